arbitro_roteamento: RTL

Round-robin arbiter that shares the 4-input NBITS-wide routing mux among four requesters. It grants one requester at a time and drives the mux select. It holds a grant for at most MAX_BURST cycles while others wait, and registers the routed data with a valid flag. It sits in front of the routing datapath and is the only agent that drives SEL.

---
 rtl/arbitro_roteamento.sv | 139 +++++++++++++
 1 files changed

// File: rtl/arbitro_roteamento.sv
// Round-robin arbiter for the 4-input routing mux with burst limit and registered data path.
module arbitro_roteamento #(
  parameter int unsigned NBITS     = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       REQ,
  input  logic [NBITS-1:0] A,
  input  logic [NBITS-1:0] B,
  input  logic [NBITS-1:0] C,
  input  logic [NBITS-1:0] D,
  output logic [3:0]       GNT,
  output logic [1:0]       SEL,
  output logic [NBITS-1:0] Saida,
  output logic             VALID
);

  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [1:0]       ptr, ptr_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [3:0]       gnt_n;
  logic [1:0]       sel_n;
  logic [NBITS-1:0] saida_n;
  logic             valid_n;

  logic [3:0]       others;
  logic             grant_en;
  logic [1:0]       grant_idx;
  logic [NBITS-1:0] routed;

  // First set bit of v, searching upward from p modulo 4.
  function automatic logic [1:0] pick(input logic [1:0] p, input logic [3:0] v);
    logic [1:0] r;
    logic [1:0] idx;
    logic       found;
    r     = p;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!found && v[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Data of the current owner, as selected by the registered SEL.
  always_comb begin
    routed = A;
    case (SEL)
      2'd0:    routed = A;
      2'd1:    routed = B;
      2'd2:    routed = C;
      default: routed = D;
    endcase
  end

  // Next-state, grant decision and data path update.
  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    cnt_n     = cnt;
    gnt_n     = GNT;
    sel_n     = SEL;
    saida_n   = Saida;
    valid_n   = 1'b0;
    grant_en  = 1'b0;
    grant_idx = SEL;
    others    = REQ & ~(4'b0001 << SEL);

    case (state)
      IDLE: begin
        if (REQ != 4'b0000) begin
          grant_en  = 1'b1;
          grant_idx = pick(ptr, REQ);
        end
      end
      GRANT: begin
        saida_n = routed;
        valid_n = 1'b1;
        if (!REQ[SEL]) begin
          if (others != 4'b0000) begin
            grant_en  = 1'b1;
            grant_idx = pick(SEL + 2'd1, others);
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            ptr_n   = SEL + 2'd1;
          end
        end else if (cnt == CW'(MAX_BURST)) begin
          // Saturated: rotate only when someone else is waiting.
          if (others != 4'b0000) begin
            grant_en  = 1'b1;
            grant_idx = pick(SEL + 2'd1, others);
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (grant_en) begin
      gnt_n   = 4'b0001 << grant_idx;
      sel_n   = grant_idx;
      ptr_n   = grant_idx + 2'd1;
      cnt_n   = CW'(1);
      state_n = GRANT;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= 2'd0;
      cnt   <= '0;
      GNT   <= 4'b0000;
      SEL   <= 2'd0;
      Saida <= '0;
      VALID <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      GNT   <= gnt_n;
      SEL   <= sel_n;
      Saida <= saida_n;
      VALID <= valid_n;
    end
  end

endmodule
